// File: rtl/spart_transmitter.sv
// SPART transmit half: one-byte holding buffer feeding a frame shifter paced by the baud enable.
// Optional build macro SPART_TX_PARITY_EN adds an even-parity bit between the MSB and the stop bit.
module spart_transmitter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iocs,
    input  logic              iorw,
    input  logic [1:0]        ioaddr,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              enable,
    output logic              txd,
    output logic              tbr,
    output logic              tx_busy,
    output logic              dbg_state
);

`ifdef SPART_TX_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 3;
`else
    localparam int FRAME_LEN = DATA_W + 2;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XMIT = 1'b1;

    logic [0:0]           r_state;
    logic [DATA_W-1:0]    r_hold;
    logic                 r_hold_valid;
    logic                 r_tbr;
    logic [FRAME_LEN-1:0] r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_txd;
    logic                 r_busy;

    logic                 w_wr_accept;
    logic                 w_load;
    logic [FRAME_LEN-1:0] w_frame;
    logic [0:0]           w_state_nxt;
    logic [FRAME_LEN-1:0] w_shift_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_busy_nxt;
    logic                 w_hold_valid_nxt;
    logic                 w_txd_nxt;

    // Bus write handshake: a write is taken only when iocs && !iorw && ioaddr==0 while
    // tbr=1; with tbr=0 the byte is dropped, the bus is never stalled.
    assign w_wr_accept = iocs && !iorw && (ioaddr == 2'b00) && r_tbr;

    // In XMIT the counter is never 0, so cnt==1 marks the end of the stop bit.
    assign w_load = r_hold_valid && enable && ((r_state == IDLE) || (r_cnt == CNT_W'(1)));

`ifdef SPART_TX_PARITY_EN
    assign w_frame = {1'b1, ^r_hold, r_hold, 1'b0};
`else
    assign w_frame = {1'b1, r_hold, 1'b0};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        if (w_load) begin
            w_state_nxt = XMIT;
            w_shift_nxt = w_frame;
            w_cnt_nxt   = CNT_W'(FRAME_LEN);
            w_busy_nxt  = 1'b1;
        end else if ((r_state == XMIT) && enable) begin
            w_shift_nxt = {1'b1, r_shift[FRAME_LEN-1:1]};
            if (r_cnt == CNT_W'(1)) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_hold_valid_nxt = r_hold_valid;
        if (w_load) begin
            w_hold_valid_nxt = 1'b0;
        end else if (w_wr_accept) begin
            w_hold_valid_nxt = 1'b1;
        end
    end

    // txd is registered from the post-edge frame so the start bit appears on the loading edge.
    assign w_txd_nxt = (w_state_nxt == XMIT) ? w_shift_nxt[0] : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_tbr        <= 1'b1;
            r_shift      <= '1;
            r_cnt        <= '0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_cnt        <= w_cnt_nxt;
            r_busy       <= w_busy_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_tbr        <= !w_hold_valid_nxt;
            r_txd        <= w_txd_nxt;
            if (w_wr_accept) begin
                r_hold <= tx_data;
            end
        end
    end

    assign txd       = r_txd;
    assign tbr       = r_tbr;
    assign tx_busy   = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_spart_transmitter.sv
// Bench for spart_transmitter: a queue-based frame model checked every cycle, plus literal bit patterns.
// Honours SPART_TX_PARITY_EN the same way as the design.
module tb_spart_transmitter;

    localparam int DATA_W = 8;
`ifdef SPART_TX_PARITY_EN
    localparam int FL = DATA_W + 3;
`else
    localparam int FL = DATA_W + 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              iocs = 1'b0;
    logic              iorw = 1'b0;
    logic [1:0]        ioaddr = 2'b00;
    logic [DATA_W-1:0] tx_data = '0;
    logic              enable = 1'b0;
    logic              txd;
    logic              tbr;
    logic              tx_busy;
    logic              dbg_state;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    spart_transmitter #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .tx_data(tx_data), .enable(enable), .txd(txd), .tbr(tbr),
        .tx_busy(tx_busy), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // exp_q: bytes waiting in the holding buffer; frame_q: bits still to appear on the wire,
    // the front one being the bit currently on txd.
    logic [DATA_W-1:0] exp_q[$];
    logic              frame_q[$];
    logic              m_txd = 1'b1;
    logic              m_tbr = 1'b1;
    logic              m_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            frame_q.delete();
            m_txd  = 1'b1;
            m_tbr  = 1'b1;
            m_busy = 1'b0;
        end else begin
            logic acc;
            logic [DATA_W-1:0] b;
            acc = iocs && !iorw && (ioaddr == 2'b00) && (exp_q.size() == 0);
            if (enable) begin
                if (frame_q.size() > 0) void'(frame_q.pop_front());
                if ((frame_q.size() == 0) && (exp_q.size() > 0)) begin
                    b = exp_q.pop_front();
                    frame_q.push_back(1'b0);
                    for (int i = 0; i < DATA_W; i++) frame_q.push_back(b[i]);
`ifdef SPART_TX_PARITY_EN
                    frame_q.push_back(^b);
`endif
                    frame_q.push_back(1'b1);
                end
            end
            if (acc) exp_q.push_back(tx_data);
            m_busy = (frame_q.size() > 0);
            m_txd  = m_busy ? frame_q[0] : 1'b1;
            m_tbr  = (exp_q.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_txd", txd, m_txd);
            check("cyc_tbr", tbr, m_tbr);
            check("cyc_busy", tx_busy, m_busy);
        end
    end

    // ---------------- drivers ----------------
    logic cap_q[$];
    int   busy_cnt = 0;
    bit   busy_cnt_on = 1'b0;

    always @(negedge clk) if (busy_cnt_on && tx_busy) busy_cnt++;

    task automatic bus_write(input logic cs, input logic rw, input logic [1:0] addr,
                             input logic [DATA_W-1:0] d);
        iocs = cs; iorw = rw; ioaddr = addr; tx_data = d;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    endtask

    // One baud tick followed by a gap; records txd right after the tick edge.
    task automatic en_pulse(input int period);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        cap_q.push_back(txd);
        repeat (period - 1) @(negedge clk);
    endtask

    function automatic logic [DATA_W-1:0] decode(input int start);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W; i++) d[i] = cap_q[start + 1 + i];
        return d;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0]  pat_a5;
        logic [10:0] pat_07;
        pat_a5 = 10'b11_0100_1010;
        pat_07 = 11'b110_0000_1110;

        repeat (3) @(negedge clk);
        check("reset_txd", txd, 1'b1);
        check("reset_tbr", tbr, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);

`ifndef SPART_TX_PARITY_EN
        // single byte, literal 8N1 pattern
        cap_q.delete();
        bus_write(1'b1, 1'b0, 2'b00, 8'hA5);
        check("a5_tbr_after_write", tbr, 1'b0);
        en_pulse(16);
        check("a5_tbr_after_first_enable", tbr, 1'b1);
        for (int i = 1; i < 10; i++) en_pulse(16);
        for (int i = 0; i < 10; i++) check("a5_bit", cap_q[i], pat_a5[i]);
        check("a5_busy_before_last", tx_busy, 1'b1);
        en_pulse(16);
        check("a5_busy_end", tx_busy, 1'b0);
`else
        cap_q.delete();
        bus_write(1'b1, 1'b0, 2'b00, 8'h07);
        for (int i = 0; i < FL + 1; i++) en_pulse(8);
        for (int i = 0; i < 11; i++) check("p07_bit", cap_q[i], pat_07[i]);
        cap_q.delete();
        bus_write(1'b1, 1'b0, 2'b00, 8'hA5);
        for (int i = 0; i < FL + 1; i++) en_pulse(8);
        check("pa5_parity", cap_q[9], 1'b0);
        check("pa5_data", decode(0), 8'hA5);
`endif

        // back-to-back frames through the holding buffer
        cap_q.delete();
        busy_cnt = 0;
        busy_cnt_on = 1'b1;
        bus_write(1'b1, 1'b0, 2'b00, 8'h3C);
        for (int i = 0; i < 3; i++) en_pulse(16);
        bus_write(1'b1, 1'b0, 2'b00, 8'hFF);
        for (int i = 3; i < 2 * FL + 2; i++) en_pulse(16);
        busy_cnt_on = 1'b0;
        check("b2b_first_byte", decode(0), 8'h3C);
        check("b2b_first_stop", cap_q[FL-1], 1'b1);
        check("b2b_second_start", cap_q[FL], 1'b0);
        check("b2b_second_byte", decode(FL), 8'hFF);
        // 2*FL bit periods of 16 clocks, plus the one clock spent on the second write
        check("b2b_busy_cycles", busy_cnt, 2 * FL * 16 + 1);

        // third write while the buffer is full is dropped
        cap_q.delete();
        bus_write(1'b1, 1'b0, 2'b00, 8'h11);
        en_pulse(1);
        bus_write(1'b1, 1'b0, 2'b00, 8'h22);
        bus_write(1'b1, 1'b0, 2'b00, 8'h33);
        check("drop_tbr_full", tbr, 1'b0);
        for (int i = 1; i < 2 * FL + 3; i++) en_pulse(6);
        check("drop_byte0", decode(0), 8'h11);
        check("drop_byte1", decode(FL), 8'h22);
        check("drop_no_third", cap_q[2 * FL], 1'b1);
        check("drop_idle_busy", tx_busy, 1'b0);

        // non-transmit bus cycles have no effect
        cap_q.delete();
        bus_write(1'b1, 1'b1, 2'b00, 8'h5A);
        check("ign_read_tbr", tbr, 1'b1);
        bus_write(1'b1, 1'b0, 2'b01, 8'h5A);
        check("ign_addr_tbr", tbr, 1'b1);
        bus_write(1'b0, 1'b0, 2'b00, 8'h5A);
        check("ign_cs_tbr", tbr, 1'b1);
        for (int i = 0; i < 3; i++) en_pulse(5);
        for (int i = 0; i < 3; i++) check("ign_txd", cap_q[i], 1'b1);
        check("ign_busy", tx_busy, 1'b0);

        // asynchronous reset in the middle of a frame
        bus_write(1'b1, 1'b0, 2'b00, 8'h00);
        for (int i = 0; i < 3; i++) en_pulse(4);
        check("rst_pre_busy", tx_busy, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_txd", txd, 1'b1);
        check("rst_async_tbr", tbr, 1'b1);
        check("rst_async_busy", tx_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            enable = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) begin
                iocs    = ($urandom_range(0, 7) != 0);
                iorw    = ($urandom_range(0, 5) == 0);
                ioaddr  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
                tx_data = DATA_W'($urandom);
            end else begin
                iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
            end
            @(negedge clk);
        end
        enable = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        for (int i = 0; i < 2 * FL + 2; i++) en_pulse(3);
        check("final_tbr", tbr, 1'b1);
        check("final_busy", tx_busy, 1'b0);
        check("final_txd", txd, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
